// File: rtl/score_pkg.sv
// Shared definitions for the score BCD converter: FSM encoding, display constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package score_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Shown on the display while game over is flagged and the blink phase is high.
  localparam logic [15:0] DEAD_WORD = 16'hDEAD;

  // Game-over marker before truncation to the score width: all ones.
  localparam logic [63:0] SENTINEL_DFLT = '1;

endpackage

// File: rtl/score_bcd_unit_dabble_step.sv
// One BCD digit correction for double dabble: add 3 when the digit is 5 or more.
// Latency: combinational.
// Backpressure: none.
// Ports: digit - BCD digit before the shift; adj - corrected digit, ready to shift.
module bcd_dabble_step (
  input  logic [3:0] digit,
  input  logic [3:0] adj_unused_guard_n,
  output logic [3:0] adj
);

  logic [3:0] plus3;

  assign plus3 = digit + 4'd3;

  always_comb begin
    adj = digit;
    if (digit >= 4'd5) begin
      adj = plus3 & ~adj_unused_guard_n;
    end
  end

endmodule

// File: rtl/score_bcd_unit.sv
// Binary score to packed BCD via serial double dabble, with game-over marker and overflow flag.
// Latency: HEX_W+1 cycles from the accepting edge to the done pulse; a pending load restarts from DONE.
// Backpressure: none; a load arriving while busy lands in a 1-deep pending slot, newest load wins.
//
// Ports:
//   clk, RSTN            clock; asynchronous active-low reset
//   load_valid/load_data score to convert, or SENTINEL to flag game over (accepted in any state)
//   clr                  clears game_over and ovf (SENTINEL load in the same cycle wins)
//   flash                blink phase; selects the DEAD display while game over
//   busy, done           busy during SHIFT; done pulses once per completed conversion
//   bcd_out, disp_out    last converted score; display word
//   game_over, ovf       sticky flags
//   hiscore_bcd          best non-overflowing score in BCD (only with SCORE_HISCORE_EN defined)
module score_bcd_unit
  import score_pkg::*;
#(
  parameter int                HEX_W    = 32,
  parameter int                DIGITS   = 8,
  parameter logic [HEX_W-1:0]  SENTINEL = HEX_W'(SENTINEL_DFLT)
) (
  input  logic                clk,
  input  logic                RSTN,
  input  logic                load_valid,
  input  logic [HEX_W-1:0]    load_data,
  input  logic                clr,
  input  logic                flash,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic [4*DIGITS-1:0] disp_out,
  output logic                game_over,
`ifdef SCORE_HISCORE_EN
  output logic [4*DIGITS-1:0] hiscore_bcd,
`endif
  output logic                ovf
);

  localparam int                BW       = 4 * DIGITS;
  localparam int                CNT_W    = (HEX_W > 1) ? $clog2(HEX_W) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HEX_W - 1);
  localparam logic [BW-1:0]     ALL_NINE = {DIGITS{4'h9}};
  localparam logic [BW-1:0]     DEAD_EXT = BW'(DEAD_WORD);

  state_t             state;
  state_t             state_nxt;

  logic [HEX_W-1:0]   shreg;
  logic [BW-1:0]      acc;
  logic [BW-1:0]      adj;
  logic [BW-1:0]      acc_sh;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_run;
  logic               pend_vld;
  logic [HEX_W-1:0]   pend_dat;

  logic               new_load;
  logic               sent_load;
  logic               start;
  logic [HEX_W-1:0]   start_dat;

  assign sent_load = load_valid && (load_data == SENTINEL);
  assign new_load  = load_valid && (load_data != SENTINEL);

  // Entering SHIFT from IDLE or DONE. A fresh load in DONE is newer than the
  // pending one, so it is taken directly and the pending slot is dropped.
  assign start     = (state_nxt == ST_SHIFT) && (state != ST_SHIFT);
  assign start_dat = (state == ST_DONE && !new_load) ? pend_dat : load_data;

  // All digits are corrected in parallel, then the whole accumulator shifts
  // left by one, pulling in the next binary MSB. A 1 leaving the top digit
  // means the score needs more than DIGITS digits.
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      bcd_dabble_step u_step (
        .digit              (acc[4*g +: 4]),
        .adj_unused_guard_n (4'h0),
        .adj                (adj[4*g +: 4])
      );
    end
  endgenerate

  assign acc_sh = {adj[BW-2:0], shreg[HEX_W-1]};
  assign carry  = adj[BW-1];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (new_load) state_nxt = ST_SHIFT;
      ST_SHIFT: if (cnt == CNT_LAST) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = (new_load || pend_vld) ? ST_SHIFT : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state == ST_SHIFT);
  end

  // ---------------- conversion datapath ----------------
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      shreg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_run  <= 1'b0;
      pend_vld <= 1'b0;
      pend_dat <= '0;
      bcd_out  <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;

      if (start) begin
        shreg   <= start_dat;
        acc     <= '0;
        cnt     <= '0;
        ovf_run <= 1'b0;
      end else if (state == ST_SHIFT) begin
        shreg <= shreg << 1;
        acc   <= acc_sh;
        cnt   <= cnt + CNT_W'(1);
        if (carry) begin
          ovf_run <= 1'b1;
        end
      end

      if (state == ST_SHIFT && new_load) begin
        pend_vld <= 1'b1;
        pend_dat <= load_data;
      end else if (start) begin
        pend_vld <= 1'b0;
      end

      if (state == ST_DONE) begin
        done    <= 1'b1;
        bcd_out <= ovf_run ? ALL_NINE : acc;
      end
    end
  end

  // ---------------- sticky flags ----------------
  // clr never touches the conversion itself; an overflowing conversion that
  // finishes after clr still raises ovf.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      game_over <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (sent_load) begin
        game_over <= 1'b1;
      end else if (clr) begin
        game_over <= 1'b0;
      end

      if (state == ST_DONE && ovf_run) begin
        ovf <= 1'b1;
      end else if (clr) begin
        ovf <= 1'b0;
      end
    end
  end

`ifdef SCORE_HISCORE_EN
  // ---------------- high score ----------------
  logic [HEX_W-1:0] cap;
  logic [HEX_W-1:0] max_bin;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      cap         <= '0;
      max_bin     <= '0;
      hiscore_bcd <= '0;
    end else begin
      if (start) begin
        cap <= start_dat;
      end
      if (state == ST_DONE && !ovf_run && cap > max_bin) begin
        max_bin     <= cap;
        hiscore_bcd <= acc;
      end
    end
  end
`endif

  assign disp_out = (game_over && flash) ? DEAD_EXT : bcd_out;

endmodule

// File: tb/tb_score_bcd_unit.sv
// Directed-vector bench for score_bcd_unit (default 32-bit score, 8 digits).
// Latency: n/a.
// Backpressure: n/a.
module tb_score_bcd_unit;

  logic        clk;
  logic        RSTN;
  logic        load_valid;
  logic [31:0] load_data;
  logic        clr;
  logic        flash;
  logic        busy;
  logic        done;
  logic [31:0] bcd_out;
  logic [31:0] disp_out;
  logic        game_over;
  logic        ovf;
`ifdef SCORE_HISCORE_EN
  logic [31:0] hiscore_bcd;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  score_bcd_unit #(.HEX_W(32), .DIGITS(8)) dut (
    .clk         (clk),
    .RSTN        (RSTN),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .clr         (clr),
    .flash       (flash),
    .busy        (busy),
    .done        (done),
    .bcd_out     (bcd_out),
    .disp_out    (disp_out),
    .game_over   (game_over),
`ifdef SCORE_HISCORE_EN
    .hiscore_bcd (hiscore_bcd),
`endif
    .ovf         (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one load for a single cycle, then watches until done (bounded).
  // Index k counts edges after the accepting edge; clr is pulsed at k == clr_at.
  task automatic run_conv(input logic [31:0] v, input int clr_at,
                          output int busy_cyc, output int done_at);
    load_valid = 1'b1;
    load_data  = v;
    step();
    load_valid = 1'b0;
    load_data  = '0;
    busy_cyc   = 0;
    done_at    = -1;
    for (int k = 0; k < 100; k++) begin
      clr = (k == clr_at);
      if (busy) busy_cyc++;
      if (done) begin
        done_at = k;
        break;
      end
      step();
    end
    clr = 1'b0;
  endtask

  task automatic send_sentinel();
    load_valid = 1'b1;
    load_data  = 32'hFFFF_FFFF;
    step();
    load_valid = 1'b0;
    load_data  = '0;
  endtask

  initial begin
    int bc, da;
    int pulses, first_k, second_k;
    logic [31:0] r1, r2;

    RSTN = 1'b0; load_valid = 1'b0; load_data = '0; clr = 1'b0; flash = 1'b1;
    pulses = 0; first_k = -1; second_k = -1; r1 = '0; r2 = '0;

    // Reset state
    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd_out, 0);
    chk("rst_disp", disp_out, 0);
    chk("rst_go", game_over, 0);
    chk("rst_ovf", ovf, 0);
`ifdef SCORE_HISCORE_EN
    chk("rst_hi", hiscore_bcd, 0);
`endif
    RSTN = 1'b1;
    step();

    // 2048: 32 busy cycles, done 33 edges after acceptance
    run_conv(32'd2048, -1, bc, da);
    chk("c2048_busy", bc, 32);
    chk("c2048_done_at", da, 33);
    chk("c2048_bcd", bcd_out, 32'h0000_2048);
    step();
    chk("c2048_done_1cyc", done, 0);

    // Sentinel: flags game over, no conversion, bcd_out kept
    flash = 1'b1;
    send_sentinel();
    chk("sent_go", game_over, 1);
    chk("sent_busy", busy, 0);
    chk("sent_bcd", bcd_out, 32'h0000_2048);
    chk("sent_disp_flash", disp_out, 32'h0000_DEAD);
    flash = 1'b0;
    #1;
    chk("sent_disp_noflash", disp_out, 32'h0000_2048);

    // Largest value that fits
    run_conv(32'd99999999, -1, bc, da);
    chk("c9s_bcd", bcd_out, 32'h9999_9999);
    chk("c9s_ovf", ovf, 0);

    // First value that does not fit
    run_conv(32'd100000000, -1, bc, da);
    chk("c1e8_done_at", da, 33);
    chk("c1e8_ovf", ovf, 1);
    chk("c1e8_bcd", bcd_out, 32'h9999_9999);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_ovf", ovf, 0);
    chk("clr_go", game_over, 0);

    // Sentinel and clr in the same cycle: sentinel wins
    load_valid = 1'b1; load_data = 32'hFFFF_FFFF; clr = 1'b1;
    step();
    load_valid = 1'b0; load_data = '0; clr = 1'b0;
    chk("sent_over_clr_go", game_over, 1);

    // 16, 32, 64 back to back: 32 is overwritten by 64 in the pending slot
    load_valid = 1'b1; load_data = 32'd16; step();
    load_data = 32'd32; step();
    load_data = 32'd64; step();
    load_valid = 1'b0; load_data = '0;
    for (int k = 2; k < 120; k++) begin
      if (done) begin
        pulses++;
        if (pulses == 1) begin first_k = k; r1 = bcd_out; end
        if (pulses == 2) begin second_k = k; r2 = bcd_out; end
      end
      step();
    end
    chk("b2b_pulses", pulses, 2);
    chk("b2b_first", r1, 32'h0000_0016);
    chk("b2b_second", r2, 32'h0000_0064);
    chk("b2b_gap", second_k - first_k, 33);

    // clr mid-conversion does not abort it; the overflow still lands
    run_conv(32'hFFFF_FFFE, 5, bc, da);
    chk("clrmid_done_at", da, 33);
    chk("clrmid_go", game_over, 0);
    chk("clrmid_ovf", ovf, 1);
    chk("clrmid_bcd", bcd_out, 32'h9999_9999);

    // Reset in SHIFT cycle 10: everything clears at once, no late done
    send_sentinel();
    flash = 1'b1;
    load_valid = 1'b1; load_data = 32'd2048;
    step();
    load_valid = 1'b0; load_data = '0;
    repeat (9) step();
    chk("rstmid_pre_busy", busy, 1);
    RSTN = 1'b0;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_bcd", bcd_out, 0);
    chk("rstmid_disp", disp_out, 0);
    chk("rstmid_go", game_over, 0);
    chk("rstmid_ovf", ovf, 0);
    repeat (2) step();
    RSTN = 1'b1;
    pulses = 0;
    bc = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (done) pulses++;
      if (busy) bc++;
    end
    chk("rstmid_no_done", pulses, 0);
    chk("rstmid_no_busy", bc, 0);
    flash = 1'b0;

`ifdef SCORE_HISCORE_EN
    run_conv(32'd512, -1, bc, da);
    chk("hi512_hi", hiscore_bcd, 32'h0000_0512);
    run_conv(32'd128, -1, bc, da);
    chk("hi128_hi", hiscore_bcd, 32'h0000_0512);
    chk("hi128_bcd", bcd_out, 32'h0000_0128);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/score_bcd_unit.md
SCORE_BCD_UNIT -- requirements
Module: score_bcd_unit

Interface
REQ-001 SHALL have parameter HEX_W, default 32, binary score width.
REQ-002 SHALL have parameter DIGITS, default 8, BCD digit count (legal range 4..10).
REQ-003 SHALL have parameter SENTINEL, default all-ones of HEX_W, the game-over marker value.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port RSTN  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port load_valid  in  1  load_data qualifier.
REQ-007 SHALL have port load_data  in  HEX_W  binary score, or SENTINEL.
REQ-008 SHALL have port clr  in  1  clears game_over and ovf.
REQ-009 SHALL have port flash  in  1  blink phase for game-over display.
REQ-010 SHALL have port busy  out  1  conversion in progress.
REQ-011 SHALL have port done  out  1  one-cycle pulse, bcd_out updated.
REQ-012 SHALL have port bcd_out  out  4*DIGITS  last converted score, packed BCD.
REQ-013 SHALL have port disp_out  out  4*DIGITS  display word.
REQ-014 SHALL have port game_over  out  1  sticky sentinel seen.
REQ-015 SHALL have port ovf  out  1  sticky, last score exceeded DIGITS.

Function
REQ-016 SHALL implement FSM IDLE -> SHIFT -> DONE -> IDLE (or DONE -> SHIFT when pending valid).
REQ-017 SHALL accept load_valid with non-SENTINEL data in IDLE: capture into shift register, clear BCD accumulator, enter SHIFT next edge.
REQ-018 SHALL spend exactly HEX_W cycles in SHIFT, one shift-and-add-3 (double dabble) step per cycle, all digits in parallel.
REQ-019 SHALL, in DONE, register bcd_out, pulse done, deassert busy; latency accept-edge to done = HEX_W+1 cycles.
REQ-020 SHALL hold busy high in SHIFT only.
REQ-021 SHALL, on load_valid while not IDLE, store data in a 1-deep pending register; newer load overwrites older; pending starts from DONE with no IDLE cycle.
REQ-022 SHALL treat load_data == SENTINEL as set game_over, never converted, never pending; bcd_out unchanged; accepted in any state.
REQ-023 SHALL detect overflow when a 1 is shifted out of the top digit; then bcd_out = all 9s, ovf set.
REQ-024 SHALL drive disp_out = 0xDEAD zero-extended when game_over and flash, else bcd_out.
REQ-025 SHALL give SENTINEL load priority over clr in the same cycle (game_over ends set).
REQ-026 SHALL clear game_over/ovf on clr without aborting a running conversion; ovf from that conversion still sets at DONE.

Reset
REQ-027 SHALL, on RSTN low, immediately force IDLE, busy=0, done=0, bcd_out=0, disp_out=0, game_over=0, ovf=0, pending invalid, hiscore cleared.
REQ-028 SHALL discard any in-flight conversion on reset; no done pulse follows.

Configuration
REQ-029 SHALL, with SCORE_HISCORE_EN defined, add output hiscore_bcd (4*DIGITS) plus binary max register; on DONE without overflow, if captured value > max, update max and hiscore_bcd; reset value 0.
REQ-030 SHALL, without SCORE_HISCORE_EN, omit port hiscore_bcd and its registers entirely.

Structure
REQ-031 SHALL place FSM state enum, DEAD display constant and default SENTINEL in shared package score_pkg.
REQ-032 SHALL use one sub-module bcd_dabble_step: combinational per-digit add-3-if-≥5, instantiated DIGITS times.

Verification
REQ-033 SHALL test load 2048 in IDLE -> busy 32 cycles, done at cycle 33, bcd_out 0x00002048.
REQ-034 SHALL test load 0xFFFFFFFF after 2048 -> game_over=1, bcd_out stays 0x00002048, disp_out 0x0000DEAD when flash=1, 0x00002048 when flash=0.
REQ-035 SHALL test load 100000000 (DIGITS=8) -> ovf=1, bcd_out 0x99999999; clr -> ovf=0.
REQ-036 SHALL test loads 16, 32, 64 on consecutive cycles -> exactly two done pulses, results 0x00000016 then 0x00000064.
REQ-037 SHALL test RSTN low at SHIFT cycle 10 -> all outputs 0 same cycle, no done after release.
REQ-038 SHALL test, with SCORE_HISCORE_EN, loads 512 then 128 -> hiscore_bcd 0x00000512, bcd_out 0x00000128.
